// File: rtl/diffeq_pkg.sv
// Shared constants and helpers for the parametrised difference-equation IIR.
// Reset coefficients reproduce y = x - x1 + x2 + x3 + 0.5*y1 + 0.25*y2 at CF=6.
package diffeq_pkg;

  localparam int N_DEF  = 16;
  localparam int NB_DEF = 4;
  localparam int NA_DEF = 2;
  localparam int CW_DEF = 8;
  localparam int CF_DEF = 6;

  // Bank index k < nb is b_k; index nb+j holds a_(j+1). Taps beyond the legacy set reset to 0.
  function automatic int coef_reset(int k, int nb);
    int v;
    v = 0;
    if (k < nb) begin
      case (k)
        0:       v = 64;
        1:       v = -64;
        2:       v = 64;
        3:       v = 64;
        default: v = 0;
      endcase
    end else begin
      case (k - nb)
        0:       v = 32;
        1:       v = 16;
        default: v = 0;
      endcase
    end
    return v;
  endfunction

  // Wide enough that no product or partial sum can overflow.
  function automatic int acc_width(int n, int cw, int nb, int na);
    return n + cw + $clog2(nb + na) + 1;
  endfunction

  function automatic longint sat_max(int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  function automatic longint sat_min(int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/diffeq_coef_bank.sv
// Runtime-writable coefficient register file, all taps presented in parallel.
// Writes to addresses past the last tap fall through the decode and are dropped.
module diffeq_coef_bank
  import diffeq_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int NA = NA_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic                          i_we,
  input  logic [$clog2(NB+NA)-1:0]      i_addr,
  input  logic [CW-1:0]                 i_data,
  output logic [(NB+NA)*CW-1:0]         o_coef
);

  localparam int NT = NB + NA;
  localparam int AB = $clog2(NB + NA);

  logic [CW-1:0] coef [NT];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NT; k++) begin
      if (!i_rst_n)
        coef[k] <= CW'(coef_reset(k, NB));
      else if (i_we && (i_addr == AB'(k)))
        coef[k] <= i_data;
    end
  end

  for (genvar k = 0; k < NT; k++) begin : g_out
    assign o_coef[k*CW +: CW] = coef[k];
  end

endmodule

// File: rtl/diffeq_iir.sv
// Direct-form-I IIR: y[n] = sum b_k*x[n-k] + sum a_k*y[n-k], advancing on valid samples only.
// Define DIFFEQ_IIR_SAT_EN to clamp out-of-range results instead of wrapping them.
module diffeq_iir
  import diffeq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int NB = NB_DEF,
  parameter int NA = NA_DEF,
  parameter int CW = CW_DEF,
  parameter int CF = CF_DEF
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic [N-1:0]              i_x,
  input  logic                      i_coef_we,
  input  logic [$clog2(NB+NA)-1:0]  i_coef_addr,
  input  logic [CW-1:0]             i_coef_data,
  output logic [N-1:0]              o_y,
  output logic                      o_valid,
  output logic                      o_sat
);

  localparam int AW = acc_width(N, CW, NB, NA);
  localparam int XH = (NB > 1) ? NB - 1 : 1;

  logic [(NB+NA)*CW-1:0]  coef_flat;
  logic signed [CW-1:0]   cb [NB];
  logic signed [CW-1:0]   ca [NA];
  logic signed [N-1:0]    xt [NB];
  logic signed [N-1:0]    xh [XH];
  logic signed [N-1:0]    yh [NA];
  logic signed [AW-1:0]   acc;
  logic [N-1:0]           y_next;
  logic                   sat_next;

  diffeq_coef_bank #(.NB(NB), .NA(NA), .CW(CW)) u_bank (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_we    (i_coef_we),
    .i_addr  (i_coef_addr),
    .i_data  (i_coef_data),
    .o_coef  (coef_flat)
  );

  for (genvar k = 0; k < NB; k++) begin : g_b
    assign cb[k] = coef_flat[k*CW +: CW];
  end
  for (genvar j = 0; j < NA; j++) begin : g_a
    assign ca[j] = coef_flat[(NB+j)*CW +: CW];
  end

  // Tap 0 is the live sample; older taps come from the x history line.
  assign xt[0] = i_x;
  for (genvar k = 1; k < NB; k++) begin : g_xt
    assign xt[k] = xh[k-1];
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NB; k++)
      acc = acc + AW'(xt[k]) * AW'(cb[k]);
    for (int j = 0; j < NA; j++)
      acc = acc + AW'(yh[j]) * AW'(ca[j]);
  end

`ifdef DIFFEQ_IIR_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = AW'(sat_max(N));
  localparam logic signed [AW-1:0] Y_MIN = AW'(sat_min(N));
  logic signed [AW-1:0] shifted;

  always_comb begin
    shifted  = acc >>> CF;
    sat_next = 1'b0;
    if (shifted > Y_MAX) begin
      y_next   = N'(Y_MAX);
      sat_next = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_next   = N'(Y_MIN);
      sat_next = 1'b1;
    end else begin
      y_next   = N'(shifted);
    end
  end
`else
  assign y_next   = N'(acc >>> CF);
  assign sat_next = 1'b0;
`endif

  // The y line captures the post-saturation output so feedback matches o_y exactly.
  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clear) begin
      for (int k = 0; k < XH; k++) xh[k] <= '0;
      for (int j = 0; j < NA; j++) yh[j] <= '0;
      o_y     <= '0;
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
    end else if (i_valid) begin
      xh[0] <= i_x;
      for (int k = 1; k < XH; k++) xh[k] <= xh[k-1];
      yh[0] <= y_next;
      for (int j = 1; j < NA; j++) yh[j] <= yh[j-1];
      o_y     <= y_next;
      o_valid <= 1'b1;
      o_sat   <= sat_next;
    end else begin
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diffeq_iir.sv
// Self-checking bench for diffeq_iir: directed scenarios plus randomized traffic
// compared against a sample-history reference model of the difference equation.
module tb_diffeq_iir;
  import diffeq_pkg::*;

  localparam int N  = N_DEF;
  localparam int NB = NB_DEF;
  localparam int NA = NA_DEF;
  localparam int CW = CW_DEF;
  localparam int CF = CF_DEF;
  localparam int NT = NB + NA;
  localparam int AB = $clog2(NT);

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_valid = 1'b0;
  logic [N-1:0]  i_x = '0;
  logic          i_coef_we = 1'b0;
  logic [AB-1:0] i_coef_addr = '0;
  logic [CW-1:0] i_coef_data = '0;
  logic [N-1:0]  o_y;
  logic          o_valid;
  logic          o_sat;

  int nChecks = 0;
  int nFails  = 0;

  longint mCoef [NT];
  longint mX [$];
  longint mY [$];
  longint expY;
  longint expValid;
  longint expSat;

  always #5 clk = ~clk;

  diffeq_iir dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .i_valid     (i_valid),
    .i_x         (i_x),
    .i_coef_we   (i_coef_we),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data),
    .o_y         (o_y),
    .o_valid     (o_valid),
    .o_sat       (o_sat)
  );

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reduce a full-precision result to the output range, clamping or wrapping.
  function automatic longint fitOutput(input longint r, output longint sat);
    longint hi, lo, w;
    hi  = (longint'(1) <<< (N - 1)) - 1;
    lo  = -(longint'(1) <<< (N - 1));
    sat = 0;
`ifdef DIFFEQ_IIR_SAT_EN
    if (r > hi) begin
      sat = 1;
      return hi;
    end
    if (r < lo) begin
      sat = 1;
      return lo;
    end
    return r;
`else
    w = r & ((longint'(1) <<< N) - 1);
    if (w > hi) w = w - (longint'(1) <<< N);
    if (lo > w) w = lo;
    return w;
`endif
  endfunction

  task automatic modelReset();
    mCoef = '{64, -64, 64, 64, 32, 16};
    mX.delete();
    mY.delete();
    expY = 0;
    expValid = 0;
    expSat = 0;
  endtask

  task automatic modelStep(input logic clear, input logic valid, input longint x,
                           input logic we, input int addr, input longint data);
    longint acc, y, s;
    if (clear) begin
      mX.delete();
      mY.delete();
      expY = 0;
      expValid = 0;
      expSat = 0;
    end else if (valid) begin
      acc = mCoef[0] * x;
      for (int k = 1; k < NB; k++)
        if (k - 1 < mX.size()) acc += mCoef[k] * mX[k-1];
      for (int j = 1; j <= NA; j++)
        if (j - 1 < mY.size()) acc += mCoef[NB+j-1] * mY[j-1];
      y = fitOutput(acc >>> CF, s);
      mX.push_front(x);
      mY.push_front(y);
      if (mX.size() > NB) mX.pop_back();
      if (mY.size() > NA) mY.pop_back();
      expY = y;
      expValid = 1;
      expSat = s;
    end else begin
      expValid = 0;
      expSat = 0;
    end
    if (we && addr < NT) mCoef[addr] = data;
  endtask

  task automatic applyStimulus(input logic rst, input logic clear, input logic valid,
                               input longint x, input logic we, input int addr,
                               input longint data, input string tag);
    i_rst_n     = rst;
    i_clear     = clear;
    i_valid     = valid;
    i_x         = N'(x);
    i_coef_we   = we;
    i_coef_addr = AB'(addr);
    i_coef_data = CW'(data);
    @(posedge clk);
    if (!rst) modelReset();
    else modelStep(clear, valid, x, we, addr, data);
    #1;
    checkOutput({tag, ".y"}, longint'($signed(o_y)), expY);
    checkOutput({tag, ".valid"}, longint'(o_valid), expValid);
    checkOutput({tag, ".sat"}, longint'(o_sat), expSat);
  endtask

  task automatic sample(input longint x, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b1, x, 1'b0, 0, 0, tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, tag);
  endtask

  task automatic clearHistory(input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0, tag);
  endtask

  task automatic writeCoef(input int addr, input longint data, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, addr, data, tag);
  endtask

  task automatic impulseRun(input int gap, input string tag);
    longint impIn  [4] = '{64, 0, 0, 0};
    longint impOut [4] = '{64, -32, 64, 88};
    for (int i = 0; i < 4; i++) begin
      sample(impIn[i], tag);
      checkOutput({tag, ".const"}, longint'($signed(o_y)), impOut[i]);
      for (int g = 0; g < gap; g++) begin
        idle({tag, ".gap"});
        checkOutput({tag, ".hold"}, longint'($signed(o_y)), impOut[i]);
      end
    end
  endtask

  initial begin
    logic [N-1:0]  rx;
    logic [CW-1:0] rd;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, "reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 123, 1'b1, 0, 5, "reset_prio");
    checkOutput("reset.y0", longint'($signed(o_y)), 0);

    impulseRun(0, "impulse");
    clearHistory("clr0");
    impulseRun(3, "gapped");

    applyStimulus(1'b1, 1'b1, 1'b1, 100, 1'b0, 0, 0, "clear_valid");
    checkOutput("clear_valid.const", longint'($signed(o_y)), 0);
    sample(100, "after_clear");
    checkOutput("after_clear.const", longint'($signed(o_y)), 100);

    for (int a = 1; a < NT; a++) writeCoef(a, 0, "zero_taps");
    clearHistory("clr1");
    applyStimulus(1'b1, 1'b0, 1'b1, 64, 1'b1, 0, 32, "collision");
    checkOutput("collision.old", longint'($signed(o_y)), 64);
    sample(64, "collision_next");
    checkOutput("collision.new", longint'($signed(o_y)), 32);

    writeCoef(0, 127, "b0_max");
    clearHistory("clr2");
    sample(32767, "saturate");
`ifdef DIFFEQ_IIR_SAT_EN
    checkOutput("saturate.const", longint'($signed(o_y)), 32767);
    checkOutput("saturate.flag", longint'(o_sat), 1);
`else
    checkOutput("saturate.const", longint'($signed(o_y)), -514);
    checkOutput("saturate.flag", longint'(o_sat), 0);
`endif

    sample(1000, "pre_reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 500, 1'b0, 0, 0, "mid_reset");
    writeCoef(NT, 99, "bad_addr");
    impulseRun(0, "impulse2");

    for (int i = 0; i < 600; i++) begin
      logic rst, clr, vld, we;
      rx  = N'($urandom);
      rd  = CW'($urandom);
      rst = ($urandom_range(0, 199) != 0);
      clr = ($urandom_range(0, 19) == 0);
      vld = ($urandom_range(0, 2) != 0);
      we  = ($urandom_range(0, 9) == 0);
      applyStimulus(rst, clr, vld, longint'($signed(rx)), we,
                    int'($urandom_range(0, (1 << AB) - 1)), longint'($signed(rd)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
